// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Optional feature in the top level: WB_BYPASS_EN (in-flight write forwarding).
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int CNT_W    = 16;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-hot combinational grant.
// The pointer names the requester that wins when both ask in the same cycle.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic rr_ptr;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (|gnt) begin
      // Hand priority to whichever requester was not just served.
      rr_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU and load writeback paths.
// Define WB_BYPASS_EN to add the in-flight write forwarding compare ports.
module regfile_wb_arbiter
  import regfile_pkg::REG_ZERO;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int CNT_W  = regfile_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_stall,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic [CNT_W-1:0]  conflict_cnt
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] fwd_reg1,
  input  logic [ADDR_W-1:0] fwd_reg2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
`endif
);

  logic [1:0]        gnt;
  logic              arb_en;
  logic              accept;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              sel_nonzero;
  logic              conflict;

  // Reset also gates the arbiter so neither ready rises while held in reset.
  assign arb_en = !wb_stall && rst_n;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;

  assign sel_reg     = gnt[1] ? req1_reg  : req0_reg;
  assign sel_data    = gnt[1] ? req1_data : req0_data;
  assign sel_nonzero = (sel_reg != ADDR_W'(REG_ZERO));
  assign conflict    = req0_valid && req1_valid && !wb_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regWrite     <= 1'b0;
      writeReg     <= '0;
      writeData    <= '0;
      conflict_cnt <= '0;
    end else begin
      // An x0 write is consumed but never reaches the register file.
      regWrite <= accept && sel_nonzero;
      if (accept && sel_nonzero) begin
        writeReg  <= sel_reg;
        writeData <= sel_data;
      end
      if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_hit1  = regWrite && (writeReg == fwd_reg1) && (fwd_reg1 != ADDR_W'(REG_ZERO));
  assign fwd_hit2  = regWrite && (writeReg == fwd_reg2) && (fwd_reg2 != ADDR_W'(REG_ZERO));
  assign fwd_data1 = fwd_hit1 ? writeData : '0;
  assign fwd_data2 = fwd_hit2 ? writeData : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vectors plus a per-cycle reference model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_stall;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_reg, req1_reg;
  logic [63:0] req0_data, req1_data;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [63:0] writeData;
  logic [15:0] conflict_cnt;
`ifdef WB_BYPASS_EN
  logic [4:0]  fwd_reg1, fwd_reg2;
  logic        fwd_hit1, fwd_hit2;
  logic [63:0] fwd_data1, fwd_data2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_stall     (wb_stall),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_reg     (req0_reg),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_reg     (req1_reg),
    .req1_data    (req1_data),
    .regWrite     (regWrite),
    .writeReg     (writeReg),
    .writeData    (writeData),
    .conflict_cnt (conflict_cnt)
`ifdef WB_BYPASS_EN
    ,
    .fwd_reg1     (fwd_reg1),
    .fwd_reg2     (fwd_reg2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port this cycle and what the write port shows.
  int          m_ptr = 0;
  bit          m_we  = 1'b0;
  logic [4:0]  m_reg = '0;
  logic [63:0] m_data = '0;
  int          m_cnt = 0;
  bit          chk_en = 1'b0;

  function automatic int model_grant();
    if (!rst_n || wb_stall) return -1;
    if (req0_valid && req1_valid) return m_ptr;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = model_grant();
    if (!rst_n) begin
      m_ptr = 0; m_we = 1'b0; m_reg = '0; m_data = '0; m_cnt = 0;
      chk_en = 1'b1;
    end else begin
      m_we = 1'b0;
      if (g >= 0) begin
        m_ptr = 1 - g;
        if (((g == 1) ? req1_reg : req0_reg) != 5'd0) begin
          m_we   = 1'b1;
          m_reg  = (g == 1) ? req1_reg  : req0_reg;
          m_data = (g == 1) ? req1_data : req0_data;
        end
      end
      if (req0_valid && req1_valid && !wb_stall && m_cnt < 65535) m_cnt++;
    end
  end

  always @(negedge clk) begin
    int g;
    if (chk_en) begin
      g = model_grant();
      check("m_ready0", req0_ready, 64'(g == 0));
      check("m_ready1", req1_ready, 64'(g == 1));
      check("m_regwrite", regWrite, 64'(m_we));
      check("m_writereg", writeReg, 64'(m_reg));
      check("m_writedata", writeData, m_data);
      check("m_conflict_cnt", conflict_cnt, 64'(m_cnt));
`ifdef WB_BYPASS_EN
      check("m_fwd_hit1", fwd_hit1, 64'(m_we && m_reg == fwd_reg1 && fwd_reg1 != 0));
      check("m_fwd_hit2", fwd_hit2, 64'(m_we && m_reg == fwd_reg2 && fwd_reg2 != 0));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; wb_stall = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 64'hAA;
    req1_valid = 1'b1; req1_reg = 5'd5; req1_data = 64'hBB;
`ifdef WB_BYPASS_EN
    fwd_reg1 = '0; fwd_reg2 = '0;
`endif

    // 1: reset with both valid, then req0 wins first
    step(); step();
    check("t1_rst_ready0", req0_ready, 0);
    check("t1_rst_ready1", req1_ready, 0);
    check("t1_rst_regwrite", regWrite, 0);
    check("t1_rst_writereg", writeReg, 0);
    check("t1_rst_writedata", writeData, 0);
    check("t1_rst_cnt", conflict_cnt, 0);
    rst_n = 1'b1; #1;
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0; #1;
    check("t1_regwrite", regWrite, 1);
    check("t1_writereg", writeReg, 3);
    check("t1_writedata", writeData, 64'hAA);
    rst_n = 1'b0; step(); rst_n = 1'b1;

    // 2: sustained contention alternates grants
    req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 64'h11;
    req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 64'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
      check("t2_ready1", req1_ready, (i % 2 == 0) ? 0 : 1);
      step();
      check("t2_regwrite", regWrite, 1);
      check("t2_writereg", writeReg, (i % 2 == 0) ? 1 : 2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; #1;
    check("t2_cnt", conflict_cnt, 4);
    step();
    check("t2_idle_regwrite", regWrite, 0);
    check("t2_idle_hold", writeReg, 2);

    // 3: write to x0 is consumed without a register-file write
    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 64'hFF; #1;
    check("t3_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0; #1;
    check("t3_regwrite", regWrite, 0);
    check("t3_writereg", writeReg, 2);
    check("t3_writedata", writeData, 64'h22);

    // 4: stall blocks grants but not an already-issued write
    wb_stall = 1'b1; req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 64'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_stall_ready0", req0_ready, 0);
      step();
      check("t4_stall_regwrite", regWrite, 0);
    end
    wb_stall = 1'b0; #1;
    check("t4_ready0", req0_ready, 1);
    step();
    req0_valid = 1'b0; wb_stall = 1'b1; #1;
    check("t4_regwrite", regWrite, 1);
    check("t4_writereg", writeReg, 9);
    check("t4_writedata", writeData, 64'h99);
    step();
    wb_stall = 1'b0;
    check("t4_done", regWrite, 0);

    // same destination from both: req1 holds priority, req0 lands last
    req0_valid = 1'b1; req0_reg = 5'd6; req0_data = 64'h60;
    req1_valid = 1'b1; req1_reg = 5'd6; req1_data = 64'h61; #1;
    check("sd_ready1", req1_ready, 1);
    step();
    check("sd_first", writeData, 64'h61);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("sd_second", writeData, 64'h60);
    check("sd_reg", writeReg, 6);
    step();

    // 5: reset right after an accept clears the issued command
    req0_valid = 1'b1; req0_reg = 5'd4; req0_data = 64'h44;
    step();
    req0_valid = 1'b0; rst_n = 1'b0;
    step();
    check("t5_regwrite", regWrite, 0);
    check("t5_writereg", writeReg, 0);
    check("t5_writedata", writeData, 0);
    rst_n = 1'b1;
    step();

`ifdef WB_BYPASS_EN
    // 6: forwarding of the in-flight write
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 64'h1234;
    step();
    req0_valid = 1'b0; fwd_reg1 = 5'd7; fwd_reg2 = 5'd0; #1;
    check("t6_hit1", fwd_hit1, 1);
    check("t6_data1", fwd_data1, 64'h1234);
    check("t6_hit2", fwd_hit2, 0);
    check("t6_data2", fwd_data2, 0);
    step();
    check("t6_hit1_after", fwd_hit1, 0);
`endif

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
